// File: rtl/ins_mem_pkg.sv
// Shared definitions for the instruction-memory loader: default geometry,
// word/byte sizes and the loader state encoding.
package ins_mem_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DEPTH      = 1024;
    localparam int INS_W          = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = INS_W / BYTE_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE,
        CHK
    } state_t;

endpackage

// File: rtl/ins_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// slave is the loader's view; master is the source/memory side.
interface ins_mem_loader_if #(
    parameter int ADDR_W = ins_mem_pkg::DEF_ADDR_W
);

    logic                          in_valid;
    logic [ins_mem_pkg::BYTE_W-1:0] in_data;
    logic                          in_ready;
    logic                          wr_en;
    logic [ADDR_W-1:0]             wr_addr;
    logic [ins_mem_pkg::INS_W-1:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/ins_mem_loader_byte_packer.sv
// Packs bytes MSB-first into a 32-bit word; word_ready flags the transfer
// that completes a word, with word_next holding the completed value.
module byte_packer
    import ins_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [BYTE_W-1:0] data,
    output logic [INS_W-1:0]  word_next,
    output logic              word_ready
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [INS_W-1:0] shreg;
    logic [IDX_W-1:0] idx;

    assign word_next  = {shreg[INS_W-BYTE_W-1:0], data};
    assign word_ready = en && (idx == IDX_W'(BYTES_PER_WORD - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            shreg <= '0;
            idx   <= '0;
        end else if (en) begin
            shreg <= word_next;
            idx   <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/ins_mem_loader.sv
// Loads a program image from a byte stream into instruction memory while
// holding the CPU in reset. Optional checksum word: INS_MEM_LOADER_CHECKSUM_EN.
module ins_mem_loader
    import ins_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    ins_mem_loader_if.slave   bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int              LEN_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_cnt;
    logic [LEN_W-1:0] len_sat;
    logic             start_acc;
    logic             data_end;
    logic [INS_W-1:0] word_next;
    logic             word_ready;

    assign len_sat   = (len > DEPTH_L) ? DEPTH_L : len;
    assign start_acc = start && (state == IDLE || state == DONE);
    // Last data word written (or nothing to write): leave the data phase.
    assign data_end  = (state == LOAD  && len_q == '0) ||
                       (state == WRITE && (word_cnt + 1'b1) == len_q);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_acc),
        .en         (bus.in_valid && bus.in_ready),
        .data       (bus.in_data),
        .word_next  (word_next),
        .word_ready (word_ready)
    );

`ifdef INS_MEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;

    logic [INS_W-1:0] sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum <= '0;
            err <= 1'b0;
        end else if (start_acc) begin
            sum <= '0;
            err <= 1'b0;
        end else if (state == WRITE) begin
            sum <= sum + bus.wr_data;
        end else if (state == CHK && word_ready) begin
            err <= (word_next != sum);
        end
    end
`else
    localparam bit CHK_EN = 1'b0;

    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            len_q        <= '0;
            word_cnt     <= '0;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LOAD;
                        len_q        <= len_sat;
                        word_cnt     <= '0;
                        bus.in_ready <= (len_sat != '0);
                        cpu_hold     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                LOAD: begin
                    if (word_ready) begin
                        state        <= WRITE;
                        bus.in_ready <= 1'b0;
                        bus.wr_en    <= 1'b1;
                        bus.wr_addr  <= word_cnt[ADDR_W-1:0];
                        bus.wr_data  <= word_next;
                    end
                end
                WRITE: begin
                    state        <= LOAD;
                    word_cnt     <= word_cnt + 1'b1;
                    bus.in_ready <= 1'b1;
                end
                CHK: begin
                    if (word_ready) begin
                        state        <= DONE;
                        bus.in_ready <= 1'b0;
                        cpu_hold     <= 1'b0;
                        done         <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Overrides the LOAD/WRITE defaults above once the image is complete.
            if (data_end) begin
                busy <= 1'b0;
                if (CHK_EN) begin
                    state        <= CHK;
                    bus.in_ready <= 1'b1;
                end else begin
                    state        <= DONE;
                    bus.in_ready <= 1'b0;
                    cpu_hold     <= 1'b0;
                    done         <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed self-checking bench for ins_mem_loader; also exercises the
// checksum word when INS_MEM_LOADER_CHECKSUM_EN is defined.
module tb_ins_mem_loader;
    import ins_mem_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          cpu_hold, busy, done, err;

    ins_mem_loader_if #(.ADDR_W(AW)) bus ();

    ins_mem_loader #(.ADDR_W(AW), .DEPTH(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Write-port monitor: record every write and any overlap with in_ready.
    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];
    int            ready_bad = 0;

    always @(negedge clk) begin
        if (bus.wr_en) begin
            log_addr.push_back(bus.wr_addr);
            log_data.push_back(bus.wr_data);
            if (bus.in_ready) ready_bad++;
        end
    end

    logic [31:0] wq[$];
    logic [7:0]  stim[$];

    // Bytes of wq, MSB first, followed by the checksum word when enabled.
    task automatic build(input bit bad_chk);
        logic [31:0] s;
        s = '0;
        stim.delete();
        foreach (wq[k]) begin
            for (int b = 3; b >= 0; b--) stim.push_back(wq[k][b*8 +: 8]);
            s = s + wq[k];
        end
`ifdef INS_MEM_LOADER_CHECKSUM_EN
        s = s + 32'(bad_chk);
        for (int b = 3; b >= 0; b--) stim.push_back(s[b*8 +: 8]);
`else
        if (bad_chk) s = '0;
`endif
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic feed(input string tag, input int from, input int to, input int pct);
        int i;
        int cyc;
        i   = from;
        cyc = 0;
        while (i < to && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            bus.in_valid = ($urandom_range(99) < pct);
            bus.in_data  = stim[i];
            if (bus.in_valid && bus.in_ready) i++;
        end
        check({tag, "_bytes"}, i, to);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = (AW+1)'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_hold_released"}, cpu_hold, 0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwrites"}, log_addr.size(), wq.size());
        foreach (wq[k]) begin
            if (k < log_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, k), log_addr[k], k);
                check($sformatf("%s_data%0d", tag, k), log_data[k], wq[k]);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        repeat (2) @(negedge clk);
        check("rst_flags", {bus.in_ready, bus.wr_en, cpu_hold, busy, done, err}, 0);
        check("rst_addr", bus.wr_addr, 0);
        check("rst_data", bus.wr_data, 0);
        rst = 1'b1;

        // sum10 image, continuous stream
        wq = '{32'h44010000, 32'h8C200004, 32'h00430820,
               32'h2021FFFF, 32'h1420FFFD, 32'h90000000};
        build(1'b0);
        do_start(6);
        check("sum10_hold", cpu_hold, 1);
        check("sum10_busy", busy, 1);
        feed("sum10", 0, stim.size(), 100);
        wait_done("sum10");
        check_writes("sum10");
        check("sum10_err", err, 0);
        check("sum10_busy_end", busy, 0);

        // 50% valid throttling
        wq = '{32'hDEADBEEF, 32'h01234567};
        build(1'b0);
        do_start(2);
        feed("throttle", 0, stim.size(), 50);
        wait_done("throttle");
        check_writes("throttle");
        check("throttle_ready_in_write", ready_bad, 0);

        // zero-length load
        wq.delete();
        build(1'b0);
        do_start(0);
`ifdef INS_MEM_LOADER_CHECKSUM_EN
        feed("len0", 0, stim.size(), 100);
        wait_done("len0");
        check("len0_err", err, 0);
`else
        begin
            int c;
            c = 0;
            while (!done && c < 4) begin
                @(negedge clk);
                c++;
            end
            check("len0_latency_ok", (c <= 2), 1);
            check("len0_done", done, 1);
        end
`endif
        check("len0_nwrites", log_addr.size(), 0);

        // reset mid-load after 5 bytes
        wq = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        build(1'b0);
        do_start(3);
        feed("midrst", 0, 5, 100);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_flags", {bus.in_ready, bus.wr_en, cpu_hold, busy, done, err}, 0);
        check("midrst_addr", bus.wr_addr, 0);
        check("midrst_data", bus.wr_data, 0);
        check("midrst_nwrites", log_addr.size(), 1);
        if (log_addr.size() > 0) begin
            check("midrst_addr0", log_addr[0], 0);
            check("midrst_data0", log_data[0], 32'h11223344);
        end
        rst = 1'b1;
        wq = '{32'hCAFEF00D};
        build(1'b0);
        do_start(1);
        feed("after_rst", 0, stim.size(), 100);
        wait_done("after_rst");
        check_writes("after_rst");

        // start pulsed mid-load is ignored
        wq = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F};
        build(1'b0);
        do_start(3);
        feed("ign_start_a", 0, 6, 100);
        @(negedge clk);
        start = 1'b1;
        len   = (AW+1)'(1);
        @(negedge clk);
        start = 1'b0;
        check("ign_start_busy", busy, 1);
        check("ign_start_done", done, 0);
        feed("ign_start_b", 6, stim.size(), 100);
        wait_done("ign_start");
        check_writes("ign_start");

`ifdef INS_MEM_LOADER_CHECKSUM_EN
        wq = '{32'h00000001, 32'hFFFFFFFF};
        build(1'b0);
        do_start(2);
        feed("chk_good", 0, stim.size(), 100);
        wait_done("chk_good");
        check_writes("chk_good");
        check("chk_good_err", err, 0);

        build(1'b1);
        do_start(2);
        feed("chk_bad", 0, stim.size(), 100);
        wait_done("chk_bad");
        check_writes("chk_bad");
        check("chk_bad_err", err, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
